// File: rtl/ledsuit_pkg.sv
// Shared WS2812 timing defaults and state encodings for the LED-suit strip drivers.
package ledsuit_pkg;

  // 50 MHz clock: 400 ns / 800 ns high times, 1.26 us bit, 50 us latch
  localparam int WS_T0H_CYCLES   = 20;
  localparam int WS_T1H_CYCLES   = 40;
  localparam int WS_BIT_CYCLES   = 63;
  localparam int WS_RESET_CYCLES = 2500;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    SEND,
    STALL,
    LATCH,
    DONE
  } drv_state_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_REL
  } fetch_state_t;

endpackage

// File: rtl/arbiter_read_port.sv
// Arbiter read handshake with address counter and a one-entry prefetch buffer.
module arbiter_read_port
  import ledsuit_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]     frame_len,
  input  logic                     consume,
  output logic [DATA_WIDTH-1:0]    buf_data,
  output logic                     buf_valid,
  output logic                     data_req,
  output logic [ADDRESS_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0]    data,
  input  logic                     data_rdy
);

  fetch_state_t           fstate, fstate_next;
  logic [LEN_WIDTH-1:0]   fetch_left;
  logic                   fill;

  always_ff @(posedge clk) begin
    if (rst) fstate <= F_IDLE;
    else     fstate <= fstate_next;
  end

  // The arbiter drops rdy a cycle after req falls, so a new request waits in
  // F_REL until rdy is seen low; otherwise the stale word would be captured.
  always_comb begin
    fstate_next = fstate;
    data_req    = 1'b0;
    fill        = 1'b0;
    unique case (fstate)
      F_IDLE: begin
        if (!buf_valid && fetch_left != '0 && !data_rdy && !load)
          fstate_next = F_REQ;
      end
      F_REQ: begin
        data_req = 1'b1;
        if (data_rdy) begin
          fill        = 1'b1;
          fstate_next = F_REL;
        end
      end
      F_REL: begin
        if (!data_rdy) fstate_next = F_IDLE;
      end
      default: fstate_next = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_addr  <= '0;
      fetch_left <= '0;
      buf_valid  <= 1'b0;
      buf_data   <= '0;
    end else if (load) begin
      data_addr  <= base_addr;
      fetch_left <= frame_len;
      buf_valid  <= 1'b0;
    end else if (fill) begin
      buf_data   <= data;
      buf_valid  <= 1'b1;
      data_addr  <= data_addr + ADDRESS_WIDTH'(1);
      fetch_left <= fetch_left - LEN_WIDTH'(1);
    end else if (consume) begin
      buf_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/ws2812_channel_driver.sv
// One WS2812 strip channel: fetches a frame through the arbiter port and
// serialises it MSB-first, followed by the latch low period and a done pulse.
module ws2812_channel_driver
  import ledsuit_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int LEN_WIDTH     = 16,
  parameter int T0H_CYCLES    = WS_T0H_CYCLES,
  parameter int T1H_CYCLES    = WS_T1H_CYCLES,
  parameter int BIT_CYCLES    = WS_BIT_CYCLES,
  parameter int RESET_CYCLES  = WS_RESET_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]     frame_len,
  output logic                     busy,
  output logic                     done,
  output logic                     underrun,
  output logic                     data_req,
  output logic [ADDRESS_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0]    data,
  input  logic                     data_rdy,
  output logic                     led_out
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int LAT_W = $clog2(RESET_CYCLES + 1);

  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] T0H        = CNT_W'(T0H_CYCLES);
  localparam logic [CNT_W-1:0] T1H        = CNT_W'(T1H_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_WIDTH - 1);
  localparam logic [LAT_W-1:0] LATCH_LAST = LAT_W'(RESET_CYCLES - 1);

  drv_state_t              state, state_next;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [CNT_W-1:0]        bit_cnt;
  logic [IDX_W-1:0]        bit_idx;
  logic [LEN_WIDTH-1:0]    send_left;
  logic [LAT_W-1:0]        latch_cnt;
  logic [DATA_WIDTH-1:0]   buf_data;
  logic                    buf_valid;
  logic                    accept, load_byte, bit_end, byte_end, bytes_remain;

  assign accept       = (state == IDLE) && start;
  assign bit_end      = (bit_cnt == BIT_LAST);
  assign byte_end     = bit_end && (bit_idx == IDX_LAST);
  assign bytes_remain = (send_left != '0);

  arbiter_read_port #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .LEN_WIDTH    (LEN_WIDTH)
  ) u_read_port (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .base_addr(base_addr),
    .frame_len(frame_len),
    .consume  (load_byte),
    .buf_data (buf_data),
    .buf_valid(buf_valid),
    .data_req (data_req),
    .data_addr(data_addr),
    .data     (data),
    .data_rdy (data_rdy)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A byte boundary with the prefetch ready reloads in the same cycle, so the
  // line sees no gap; without it the line parks low in STALL.
  always_comb begin
    state_next = state;
    load_byte  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    led_out    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = (frame_len == '0) ? LATCH : PRIME;
      end
      PRIME, STALL: begin
        busy = 1'b1;
        if (buf_valid) begin
          load_byte  = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        busy    = 1'b1;
        led_out = bit_cnt < (shift_reg[DATA_WIDTH-1] ? T1H : T0H);
        if (byte_end) begin
          if (!bytes_remain)  state_next = LATCH;
          else if (buf_valid) load_byte  = 1'b1;
          else                state_next = STALL;
        end
      end
      LATCH: begin
        busy = 1'b1;
        if (latch_cnt == LATCH_LAST) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      send_left <= '0;
      latch_cnt <= '0;
      underrun  <= 1'b0;
    end else begin
      if (accept) begin
        send_left <= frame_len;
        underrun  <= 1'b0;
      end
      if (load_byte) begin
        shift_reg <= buf_data;
        bit_cnt   <= '0;
        bit_idx   <= '0;
        send_left <= send_left - LEN_WIDTH'(1);
      end else if (state == SEND) begin
        if (bit_end) begin
          bit_cnt   <= '0;
          bit_idx   <= bit_idx + IDX_W'(1);
          shift_reg <= shift_reg << 1;
        end else begin
          bit_cnt   <= bit_cnt + CNT_W'(1);
        end
      end
      if (state == SEND && byte_end && bytes_remain && !buf_valid) underrun <= 1'b1;
      latch_cnt <= (state == LATCH) ? latch_cnt + LAT_W'(1) : '0;
    end
  end

endmodule

// File: tb/tb_ws2812_channel_driver.sv
// Self-checking bench for ws2812_channel_driver: ideal arbiter responder,
// line pulse-width monitor and a byte-level reference model.
module tb_ws2812_channel_driver;

  localparam int T0H     = 2;
  localparam int T1H     = 4;
  localparam int BITC    = 6;
  localparam int RSTC    = 10;
  localparam int TIMEOUT = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = 8'h00;
  logic [15:0] frame_len = 16'd0;
  logic        busy, done, underrun, data_req, led_out;
  logic [7:0]  data_addr;
  logic [7:0]  data = 8'h00;
  logic        data_rdy = 1'b0;

  int pass_cnt = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  ws2812_channel_driver #(
    .ADDRESS_WIDTH(8), .DATA_WIDTH(8), .LEN_WIDTH(16),
    .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .BIT_CYCLES(BITC), .RESET_CYCLES(RSTC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .frame_len(frame_len),
    .busy(busy), .done(done), .underrun(underrun), .data_req(data_req),
    .data_addr(data_addr), .data(data), .data_rdy(data_rdy), .led_out(led_out)
  );

  // Arbiter model: rdy after arb_lat request cycles (plus stall_extra for
  // fetch number stall_idx), dropped arb_hold cycles after req falls.
  logic [7:0] mem [256];
  int arb_lat = 2, arb_hold = 0, stall_idx = -1, stall_extra = 0;
  int fetch_idx = 0, req_wait = 0, hold_cnt = 0, rel_viol = 0;
  bit releasing = 0;
  int addr_q[$];

  always @(negedge clk) begin
    if (rst) begin
      data_rdy = 1'b0; req_wait = 0; hold_cnt = 0; releasing = 0;
    end else if (data_rdy) begin
      if (!data_req) begin
        releasing = 1;
        if (hold_cnt >= arb_hold) begin
          data_rdy = 1'b0; releasing = 0; hold_cnt = 0;
        end else hold_cnt++;
      end else if (releasing) rel_viol++;
    end else if (data_req) begin
      req_wait++;
      if (req_wait >= arb_lat + ((fetch_idx == stall_idx) ? stall_extra : 0)) begin
        data = mem[data_addr]; data_rdy = 1'b1;
        addr_q.push_back(int'(data_addr));
        fetch_idx++; req_wait = 0;
      end
    end
  end

  int widths[$];
  int hi_cnt = 0, low_run = 0, done_cnt = 0, low_at_done = -1;

  always @(negedge clk) begin
    if (done) begin done_cnt++; low_at_done = low_run; end
    if (led_out) begin hi_cnt++; low_run = 0; end
    else begin
      if (hi_cnt > 0) begin widths.push_back(hi_cnt); hi_cnt = 0; end
      low_run++;
    end
  end

  int exp_w[$];
  int exp_a[$];

  function automatic void expect_frame(input int base, input int len);
    exp_w.delete(); exp_a.delete();
    for (int i = 0; i < len; i++) begin
      int a = (base + i) % 256;
      exp_a.push_back(a);
      for (int b = 7; b >= 0; b--) exp_w.push_back(mem[a][b] ? T1H : T0H);
    end
  endfunction

  function automatic int queue_diff(input int a[$], input int b[$]);
    int n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  task automatic clear_obs;
    widths.delete(); addr_q.delete();
    fetch_idx = 0; rel_viol = 0; done_cnt = 0; low_at_done = -1;
  endtask

  task automatic launch(input logic [7:0] base, input logic [15:0] len);
    clear_obs();
    base_addr = base; frame_len = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int glitch_at, output int cycles);
    cycles = 1;
    while (!done && cycles < TIMEOUT) begin
      @(negedge clk);
      cycles++;
      if (cycles == glitch_at) begin start = 1'b1; base_addr = 8'h55; frame_len = 16'd7; end
      else start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %0b want 0", busy); else pass_cnt++;
    check_cnt++; if (done !== 1'b0) $display("[TB] FAIL reset_done got %0b want 0", done); else pass_cnt++;
    check_cnt++; if (underrun !== 1'b0) $display("[TB] FAIL reset_underrun got %0b want 0", underrun); else pass_cnt++;
    check_cnt++; if (data_req !== 1'b0) $display("[TB] FAIL reset_data_req got %0b want 0", data_req); else pass_cnt++;
    check_cnt++; if (data_addr !== 8'h00) $display("[TB] FAIL reset_data_addr got %0h want 0", data_addr); else pass_cnt++;
    check_cnt++; if (led_out !== 1'b0) $display("[TB] FAIL reset_led_out got %0b want 0", led_out); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_two_byte;
    int cyc, d;
    mem[8'h10] = 8'hA5; mem[8'h11] = 8'h3C;
    arb_lat = 2; arb_hold = 0; stall_idx = -1;
    expect_frame(16, 2);
    launch(8'h10, 16'd2);
    check_cnt++; if (busy !== 1'b1) $display("[TB] FAIL two_byte_busy got %0b want 1", busy); else pass_cnt++;
    wait_done(0, cyc);
    @(negedge clk);
    check_cnt++; if (cyc != 2 + arb_lat + 2 * 8 * BITC + RSTC + 1) $display("[TB] FAIL two_byte_duration got %0d want %0d", cyc, 2 + arb_lat + 16 * BITC + RSTC + 1); else pass_cnt++;
    d = queue_diff(widths, exp_w);
    check_cnt++; if (d != -1) $display("[TB] FAIL two_byte_widths diff at %0d got %0d pulses want %0d", d, widths.size(), exp_w.size()); else pass_cnt++;
    d = queue_diff(addr_q, exp_a);
    check_cnt++; if (d != -1) $display("[TB] FAIL two_byte_addrs diff at %0d got %0d fetches want %0d", d, addr_q.size(), exp_a.size()); else pass_cnt++;
    check_cnt++; if (low_at_done != BITC - exp_w[$] + RSTC) $display("[TB] FAIL two_byte_latch got %0d low cycles want %0d", low_at_done, BITC - exp_w[$] + RSTC); else pass_cnt++;
    check_cnt++; if (done_cnt != 1) $display("[TB] FAIL two_byte_done got %0d pulses want 1", done_cnt); else pass_cnt++;
    check_cnt++; if (underrun !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL two_byte_end got underrun=%0b busy=%0b want 0 0", underrun, busy); else pass_cnt++;
  endtask

  task automatic test_handshake_release;
    int cyc, d;
    arb_lat = 2; arb_hold = 3; stall_idx = -1;
    expect_frame(16, 2);
    launch(8'h10, 16'd2);
    wait_done(0, cyc);
    @(negedge clk);
    check_cnt++; if (rel_viol != 0) $display("[TB] FAIL release_req_early got %0d violations want 0", rel_viol); else pass_cnt++;
    d = queue_diff(widths, exp_w);
    check_cnt++; if (d != -1) $display("[TB] FAIL release_widths diff at %0d got %0d pulses want %0d", d, widths.size(), exp_w.size()); else pass_cnt++;
    d = queue_diff(addr_q, exp_a);
    check_cnt++; if (d != -1) $display("[TB] FAIL release_addrs diff at %0d got %0d fetches want %0d", d, addr_q.size(), exp_a.size()); else pass_cnt++;
    arb_hold = 0;
  endtask

  task automatic test_underrun;
    int cyc, d;
    arb_lat = 2; arb_hold = 0; stall_idx = 1; stall_extra = 60;
    expect_frame(16, 2);
    launch(8'h10, 16'd2);
    wait_done(0, cyc);
    @(negedge clk);
    check_cnt++; if (underrun !== 1'b1) $display("[TB] FAIL underrun_flag got %0b want 1", underrun); else pass_cnt++;
    d = queue_diff(widths, exp_w);
    check_cnt++; if (d != -1) $display("[TB] FAIL underrun_widths diff at %0d got %0d pulses want %0d", d, widths.size(), exp_w.size()); else pass_cnt++;
    check_cnt++; if (done_cnt != 1) $display("[TB] FAIL underrun_done got %0d pulses want 1", done_cnt); else pass_cnt++;
    stall_idx = -1;
    launch(8'h10, 16'd2);
    check_cnt++; if (underrun !== 1'b0) $display("[TB] FAIL underrun_clear got %0b want 0", underrun); else pass_cnt++;
    wait_done(0, cyc);
    @(negedge clk);
    check_cnt++; if (underrun !== 1'b0) $display("[TB] FAIL underrun_clean_frame got %0b want 0", underrun); else pass_cnt++;
  endtask

  task automatic test_address_wrap;
    int cyc, d;
    mem[8'hFF] = 8'($urandom); mem[8'h00] = 8'($urandom); mem[8'h01] = 8'($urandom);
    arb_lat = 2; arb_hold = 0; stall_idx = -1;
    expect_frame(255, 3);
    launch(8'hFF, 16'd3);
    wait_done(0, cyc);
    @(negedge clk);
    d = queue_diff(addr_q, exp_a);
    check_cnt++; if (d != -1) $display("[TB] FAIL wrap_addrs diff at %0d got %0d fetches want %0d", d, addr_q.size(), exp_a.size()); else pass_cnt++;
    d = queue_diff(widths, exp_w);
    check_cnt++; if (d != -1) $display("[TB] FAIL wrap_widths diff at %0d got %0d pulses want %0d", d, widths.size(), exp_w.size()); else pass_cnt++;
  endtask

  task automatic test_zero_length;
    int cyc, d;
    launch(8'h20, 16'd0);
    wait_done(5, cyc);
    @(negedge clk);
    check_cnt++; if (cyc != RSTC + 1) $display("[TB] FAIL zero_len_duration got %0d want %0d", cyc, RSTC + 1); else pass_cnt++;
    check_cnt++; if (addr_q.size() != 0 || widths.size() != 0) $display("[TB] FAIL zero_len_activity got %0d fetches %0d pulses want 0 0", addr_q.size(), widths.size()); else pass_cnt++;
    check_cnt++; if (done_cnt != 1) $display("[TB] FAIL zero_len_done got %0d pulses want 1", done_cnt); else pass_cnt++;
    mem[8'h10] = 8'hA5; mem[8'h11] = 8'h3C;
    expect_frame(16, 2);
    launch(8'h10, 16'd2);
    wait_done(40, cyc);
    @(negedge clk);
    d = queue_diff(widths, exp_w);
    check_cnt++; if (d != -1) $display("[TB] FAIL ignored_start_widths diff at %0d got %0d pulses want %0d", d, widths.size(), exp_w.size()); else pass_cnt++;
    check_cnt++; if (addr_q.size() != 2 || done_cnt != 1) $display("[TB] FAIL ignored_start_effect got %0d fetches %0d done want 2 1", addr_q.size(), done_cnt); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int cyc, d;
    expect_frame(16, 2);
    launch(8'h10, 16'd2);
    wait_done(0, cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL start_on_done_busy got %0b want 0", busy); else pass_cnt++;
    repeat (4) @(negedge clk);
    check_cnt++; if (busy !== 1'b0 || addr_q.size() != 2) $display("[TB] FAIL start_on_done_effect got busy=%0b fetches=%0d want 0 2", busy, addr_q.size()); else pass_cnt++;
    launch(8'h10, 16'd2);
    wait_done(0, cyc);
    start = 1'b1;
    @(negedge clk);
    clear_obs();
    @(negedge clk);
    start = 1'b0;
    check_cnt++; if (busy !== 1'b1) $display("[TB] FAIL start_after_done_busy got %0b want 1", busy); else pass_cnt++;
    wait_done(0, cyc);
    @(negedge clk);
    d = queue_diff(widths, exp_w);
    check_cnt++; if (d != -1 || done_cnt != 1) $display("[TB] FAIL back_to_back_frame diff at %0d done=%0d want -1 1", d, done_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid_send;
    int n = 0, cyc, d;
    expect_frame(16, 2);
    launch(8'h10, 16'd2);
    while (!(widths.size() == 3 && led_out) && n < 500) begin @(negedge clk); n++; end
    check_cnt++; if (n >= 500) $display("[TB] FAIL mid_send_reach got %0d cycles want bit 3 within 500", n); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    check_cnt++; if (led_out !== 1'b0 || data_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("[TB] FAIL mid_send_abort got led=%0b req=%0b busy=%0b done=%0b want 0 0 0 0", led_out, data_req, busy, done); else pass_cnt++;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_cnt++; if (done_cnt != 0 || busy !== 1'b0) $display("[TB] FAIL mid_send_no_done got done=%0d busy=%0b want 0 0", done_cnt, busy); else pass_cnt++;
    launch(8'h10, 16'd2);
    wait_done(0, cyc);
    @(negedge clk);
    d = queue_diff(widths, exp_w);
    check_cnt++; if (d != -1) $display("[TB] FAIL post_reset_widths diff at %0d got %0d pulses want %0d", d, widths.size(), exp_w.size()); else pass_cnt++;
    d = queue_diff(addr_q, exp_a);
    check_cnt++; if (d != -1) $display("[TB] FAIL post_reset_addrs diff at %0d got %0d fetches want %0d", d, addr_q.size(), exp_a.size()); else pass_cnt++;
  endtask

  task automatic test_random;
    for (int it = 0; it < 4; it++) begin
      int base, len, cyc, d;
      base = $urandom_range(0, 255);
      len = $urandom_range(1, 4);
      arb_lat = $urandom_range(1, 5); arb_hold = $urandom_range(0, 2); stall_idx = -1;
      for (int i = 0; i < len; i++) mem[(base + i) % 256] = 8'($urandom);
      expect_frame(base, len);
      launch(8'(base), 16'(len));
      wait_done(0, cyc);
      @(negedge clk);
      check_cnt++; if (cyc != 2 + arb_lat + len * 8 * BITC + RSTC + 1) $display("[TB] FAIL random%0d_duration got %0d want %0d", it, cyc, 2 + arb_lat + len * 8 * BITC + RSTC + 1); else pass_cnt++;
      d = queue_diff(widths, exp_w);
      check_cnt++; if (d != -1) $display("[TB] FAIL random%0d_widths diff at %0d got %0d pulses want %0d", it, d, widths.size(), exp_w.size()); else pass_cnt++;
      d = queue_diff(addr_q, exp_a);
      check_cnt++; if (d != -1) $display("[TB] FAIL random%0d_addrs diff at %0d got %0d fetches want %0d", it, d, addr_q.size(), exp_a.size()); else pass_cnt++;
      check_cnt++; if (rel_viol != 0 || underrun !== 1'b0) $display("[TB] FAIL random%0d_handshake got viol=%0d underrun=%0b want 0 0", it, rel_viol, underrun); else pass_cnt++;
    end
    arb_lat = 2; arb_hold = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got no finish want finish before 50000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    @(negedge clk);
    test_reset();
    test_two_byte();
    test_handshake_release();
    test_underrun();
    test_address_wrap();
    test_zero_length();
    test_back_to_back();
    test_reset_mid_send();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
